// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and baud helper
package uart_pkg;

  // One-hot FSM encoding, also driven straight out to the debug LEDs
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per line bit; truncating division, caller guarantees >= 2
  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing one tick per line bit
module uart_baud_gen #(
  parameter int BIT_PERIOD = 10
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(BIT_PERIOD - 1));

  // Count 0..BIT_PERIOD-1; restart on external clear (state entry) or on the tick itself
  always_ff @(posedge clk) begin
    if (reset_p || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with valid/ready input
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [4:0]           state_dbg
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int IW         = $clog2(DATA_BITS);
  localparam bit PAR_EN     = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam bit PAR_IS_ODD = (PARITY == PAR_ODD);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [IW-1:0]        idx_q, idx_nxt;
  logic                 stop_q, stop_nxt;
  logic                 par_q, par_nxt;
  logic                 tx_q, tx_nxt;
  logic                 tick;
  logic                 baud_clear;

  // Hold the bit counter at zero while idle and restart it whenever the state changes
  assign baud_clear = (state_nxt != state) || (state == S_IDLE);

  uart_baud_gen #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_baud_gen (
    .clk     (clk),
    .reset_p (reset_p),
    .clear   (baud_clear),
    .tick    (tick)
  );

  // Next-state, datapath and line-level decode; tx is computed from the next state so the
  // registered line bit changes on the same edge as the state
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    idx_nxt   = idx_q;
    stop_nxt  = stop_q;
    par_nxt   = par_q;
    tx_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shift_nxt = tx_data;
          par_nxt   = PAR_IS_ODD ? ~^tx_data : ^tx_data;
          idx_nxt   = '0;
          stop_nxt  = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          idx_nxt   = '0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_nxt = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            stop_nxt  = 1'b0;
            state_nxt = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            idx_nxt = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          stop_nxt  = 1'b0;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            tx_done   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_q;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and parks the line high
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state   <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      idx_q   <= idx_nxt;
      stop_q  <= stop_nxt;
      par_q   <= par_nxt;
      tx_q    <= tx_nxt;
    end
  end

  assign tx        = tx_q;
  assign tx_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed scoreboard bench for uart_tx_param
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] valid_r;
  logic [8:0] data_r [4];
  logic [3:0] tx_w, ready_w, busy_w, done_w;
  logic [4:0] dbg_w [4];

  int n_assert = 0;
  int n_fail   = 0;

  // Per-instance configuration: 8N1, 8E1, 8O1, 7N2
  int db     [4] = '{8, 8, 8, 7};
  int par_m  [4] = '{0, 2, 1, 0};
  int sb     [4] = '{1, 1, 1, 2};
  localparam int P = 10;

  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_p(reset_p), .tx_data(data_r[0][7:0]), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .state_dbg(dbg_w[0]));

  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_p(reset_p), .tx_data(data_r[1][7:0]), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .state_dbg(dbg_w[1]));

  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset_p(reset_p), .tx_data(data_r[2][7:0]), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .state_dbg(dbg_w[2]));

  uart_tx_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset_p(reset_p), .tx_data(data_r[3][6:0]), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]), .state_dbg(dbg_w[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push the expected line bits, hand the word over, then walk the frame sampling mid-bit.
  // Called at a negedge while the instance is idle; returns at the negedge of the idle cycle.
  task automatic run_frame(input int idx, input logic [8:0] word, input logic [8:0] mid_data,
                           input bit keep_valid);
    int       f;
    logic [8:0] w;
    logic     pb;
    logic     e;
    w = word & ((9'd1 << db[idx]) - 9'd1);
    f = (1 + db[idx] + ((par_m[idx] != 0) ? 1 : 0) + sb[idx]) * P;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db[idx]; i++) exp_q.push_back(w[i]);
    if (par_m[idx] != 0) begin
      pb = ^w;
      if (par_m[idx] == 1) pb = ~pb;
      exp_q.push_back(pb);
    end
    for (int i = 0; i < sb[idx]; i++) exp_q.push_back(1'b1);

    check($sformatf("ready_before_accept[%0d]", idx), ready_w[idx], 1);
    valid_r[idx] = 1'b1;
    data_r[idx]  = word;
    @(negedge clk);
    for (int c = 1; c <= f + 1; c++) begin
      if (c == 1) begin
        check($sformatf("tx_low_after_accept[%0d]", idx), tx_w[idx], 0);
        check($sformatf("busy_in_frame[%0d]", idx), busy_w[idx], 1);
        if (!keep_valid) valid_r[idx] = 1'b0;
        data_r[idx] = mid_data;
      end
      if (c <= f && ((c - 1) % P) == P / 2) begin
        e = exp_q.pop_front();
        check($sformatf("line_bit[%0d]@%0d", idx, c), tx_w[idx], e);
      end
      if (c <= f) begin
        check($sformatf("tx_done_timing[%0d]@%0d", idx, c), done_w[idx], (c == f));
        @(negedge clk);
      end else begin
        check($sformatf("ready_after_frame[%0d]", idx), ready_w[idx], 1);
        check($sformatf("tx_idle_after_frame[%0d]", idx), tx_w[idx], 1);
        check($sformatf("busy_after_frame[%0d]", idx), busy_w[idx], 0);
      end
    end
  endtask

  initial begin
    int bad;
    reset_p = 1'b1;
    valid_r = '0;
    for (int i = 0; i < 4; i++) data_r[i] = '0;
    @(negedge clk);
    @(negedge clk);
    reset_p = 1'b0;

    check("reset_tx", tx_w, 4'hF);
    check("reset_ready", ready_w, 4'hF);
    check("reset_busy", busy_w, 4'h0);
    check("reset_done", done_w, 4'h0);
    check("reset_state", dbg_w[0], 5'b00001);

    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) bad++;
    end
    check("idle_quiet_cycles", bad, 0);

    run_frame(0, 9'h0A5, 9'h05A, 1'b0);
    run_frame(1, 9'h007, 9'h0F0, 1'b0);
    run_frame(2, 9'h007, 9'h0F0, 1'b0);
    run_frame(3, 9'h041, 9'h03E, 1'b0);

    // Back-to-back with tx_valid held; the second word is presented mid-frame of the first
    run_frame(0, 9'h011, 9'h022, 1'b1);
    run_frame(0, 9'h022, 9'h0CC, 1'b0);

    // Reset at cycle 45 of an 0xFF frame
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h0FF;
    @(negedge clk);
    valid_r[0] = 1'b0;
    bad = 0;
    for (int c = 1; c < 45; c++) begin
      if (done_w[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    check("busy_before_reset", busy_w[0], 1);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    check("abort_tx", tx_w[0], 1);
    check("abort_state", dbg_w[0], 5'b00001);
    check("abort_ready", ready_w[0], 1);
    check("abort_done", done_w[0], 0);
    repeat (120) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    check("abort_no_resume_no_done", bad, 0);

    // Reset and tx_valid together: nothing may be latched
    reset_p    = 1'b1;
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h03C;
    @(negedge clk);
    reset_p    = 1'b0;
    valid_r[0] = 1'b0;
    check("rst_valid_busy", busy_w[0], 0);
    check("rst_valid_state", dbg_w[0], 5'b00001);
    @(negedge clk);
    check("rst_valid_tx", tx_w[0], 1);
    check("rst_valid_busy_later", busy_w[0], 0);

    run_frame(0, 9'h0C3, 9'h000, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
